key_addition_reg: RTL and testbench
===================================

// Module: key_addition_reg
// PURPOSE
//  Registered, parametrised round-key addition (out = state ^ key) with a
//  valid/ready handshake, an internal key register and duplicated XOR
//  computation for fault detection. Sits between the state register and the
//  S-box layer of our cipher cores. A detected mismatch forces a fault
//  state that suppresses output.
// PARAMETERS
//  WIDTH      4  state/key width in bits (>=1)
//  REDUNDANT  1  1: second XOR path on complemented operands plus compare; 0: none
// PORTS
//  clock        in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  io_key       in   WIDTH  key value to load
//  io_key_load  in   1      capture io_key into key register this cycle
//  io_in_valid  in   1      io_state valid
//  io_in_ready  out  1      block can accept io_state
//  io_state     in   WIDTH  state to be keyed
//  io_out_valid out  1      io_out valid
//  io_out_ready in   1      downstream accepts io_out
//  io_out       out  WIDTH  keyed state (registered)
//  io_fault     out  1      sticky fault flag
//  io_clr_fault in   1      clear fault, return to EMPTY
// BEHAVIOUR
//  Reset (async, any cycle, incl. mid-transfer): key_reg=0, io_out=0,
//   io_out_valid=0, io_fault=0, state=EMPTY.
//  Key: io_key_load=1 -> key_reg<=io_key at next edge. Transfer in same cycle
//   uses the OLD key_reg. Load is accepted in every state.
//  States: EMPTY, FULL, FAULT (one-entry output buffer).
//   io_in_ready = (EMPTY) | (FULL & io_out_ready); 0 in FAULT.
//   io_out_valid = (state==FULL).
//  Accept (io_in_valid & io_in_ready): p = io_state ^ key_reg;
//   r = ~io_state ^ ~key_reg (REDUNDANT=1). If REDUNDANT=0 or p==r:
//   io_out<=p, state->FULL. Else: io_out<=0, io_fault<=1, state->FAULT.
//  Latency 1 cycle from accept to io_out_valid. Full throughput: in FULL with
//   io_out_ready=1 and io_in_valid=1, out drains and new word loads same edge.
//  FULL, io_out_ready=1, no accept -> EMPTY; io_out holds last value.
//  FULL, io_out_ready=0 -> hold io_out stable, io_in_ready=0.
//  FAULT: io_out=0, io_out_valid=0, io_in_ready=0 until io_clr_fault=1,
//   then io_fault<=0, state->EMPTY. io_clr_fault outside FAULT: no effect.
//  io_in_valid must not depend on io_in_ready. No width extension; bitwise only.
// TESTING
//  1 reset mid-FULL -> next cycle io_out=0, io_out_valid=0, io_fault=0, key_reg=0.
//  2 WIDTH=4: load key 4'hA, then state 4'h5 -> io_out=4'hF valid 1 cycle later.
//  3 backpressure: io_out_ready=0 with FULL, drive new state -> io_in_ready=0,
//    io_out stable; release -> old word drains, then new word.
//  4 key load same cycle as accept: key 4'h3->4'hC, state 4'h1 -> io_out=4'h2,
//    following state 4'h1 -> io_out=4'hD.
//  5 force stuck-at on redundant XOR bit0 -> io_fault=1, io_out=0, io_in_ready=0;
//    pulse io_clr_fault -> EMPTY, next transfer correct.
//  6 WIDTH=128, streaming 1000 random words with random io_out_ready -> output
//    sequence equals state^key model, no drops/dups, io_fault stays 0.

Source files
------------

// File: rtl/key_addition_reg.sv
// Registered round-key addition (out = state ^ key) behind a one-entry
// valid/ready buffer, with an optional duplicated XOR path that traps faults.
module key_addition_reg #(
  parameter int WIDTH     = 4,
  parameter bit REDUNDANT = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_key,
  input  logic             io_key_load,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_state,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out,
  output logic             io_fault,
  input  logic             io_clr_fault
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   key_reg;
  logic [WIDTH-1:0]   out_reg, out_next;
  logic               fault_reg, fault_next;

  logic [WIDTH-1:0]   p_word;
  logic [WIDTH-1:0]   r_word;
  logic               mismatch;
  logic               accept;

  // Primary path: plain XOR of the incoming state with the stored key.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_primary
      assign p_word[gi] = io_state[gi] ^ key_reg[gi];
    end
  endgenerate

  // Shadow path works on complemented operands so a single stuck node cannot
  // corrupt both results identically.
  generate
    if (REDUNDANT) begin : g_redundant
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign r_word[gi] = (~io_state[gi]) ^ (~key_reg[gi]);
      end
      assign mismatch = (p_word != r_word);
    end else begin : g_plain
      assign r_word   = p_word;
      assign mismatch = 1'b0;
    end
  endgenerate

  always_comb begin
    io_in_ready = 1'b0;
    case (state_reg)
      ST_EMPTY: io_in_ready = 1'b1;
      ST_FULL:  io_in_ready = io_out_ready;
      default:  io_in_ready = 1'b0;
    endcase
  end

  assign accept       = io_in_valid & io_in_ready;
  assign io_out_valid = (state_reg == ST_FULL);
  assign io_out       = out_reg;
  assign io_fault     = fault_reg;

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    fault_next = fault_reg;
    case (state_reg)
      ST_EMPTY, ST_FULL: begin
        if (accept) begin
          if (mismatch) begin
            out_next   = '0;
            fault_next = 1'b1;
            state_next = ST_FAULT;
          end else begin
            out_next   = p_word;
            state_next = ST_FULL;
          end
        end else if (state_reg == ST_FULL && io_out_ready) begin
          // Drained with nothing behind it; io_out keeps the last word.
          state_next = ST_EMPTY;
        end
      end
      ST_FAULT: begin
        out_next = '0;
        if (io_clr_fault) begin
          fault_next = 1'b0;
          state_next = ST_EMPTY;
        end
      end
      default: begin
        out_next   = '0;
        state_next = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_EMPTY;
      out_reg   <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      fault_reg <= fault_next;
    end
  end

  // Key loads in every state; a transfer in the same cycle still sees the old key.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_reg <= '0;
    end else if (io_key_load) begin
      key_reg <= io_key;
    end
  end

endmodule

// File: tb/tb_key_addition_reg.sv
// Directed bench for key_addition_reg: a WIDTH=4 instance for hand vectors and
// a WIDTH=128 instance for a randomised stream against a scoreboard queue.
module tb_key_addition_reg;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // 4-bit instance
  logic [3:0] a_key, a_state, a_out;
  logic       a_key_load, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic       a_fault, a_clr_fault;

  // 128-bit instance
  logic [127:0] b_key, b_state, b_out;
  logic         b_key_load, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic         b_fault, b_clr_fault;

  key_addition_reg #(.WIDTH(4), .REDUNDANT(1'b1)) dut_a (
    .clock(clk), .reset(rst),
    .io_key(a_key), .io_key_load(a_key_load),
    .io_in_valid(a_in_valid), .io_in_ready(a_in_ready), .io_state(a_state),
    .io_out_valid(a_out_valid), .io_out_ready(a_out_ready), .io_out(a_out),
    .io_fault(a_fault), .io_clr_fault(a_clr_fault)
  );

  key_addition_reg #(.WIDTH(128), .REDUNDANT(1'b1)) dut_b (
    .clock(clk), .reset(rst),
    .io_key(b_key), .io_key_load(b_key_load),
    .io_in_valid(b_in_valid), .io_in_ready(b_in_ready), .io_state(b_state),
    .io_out_valid(b_out_valid), .io_out_ready(b_out_ready), .io_out(b_out),
    .io_fault(b_fault), .io_clr_fault(b_clr_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (a_out !== 4'h0 || a_out_valid !== 1'b0 || a_fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: out=%h valid=%b fault=%b required out=0 valid=0 fault=0",
               a_out, a_out_valid, a_fault);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: in_ready=%b required 1", a_in_ready);
    end
    $display("txn reset: out=%h valid=%b fault=%b ready=%b", a_out, a_out_valid, a_fault, a_in_ready);
  endtask

  task automatic test_basic();
    @(negedge clk);
    a_key = 4'hA; a_key_load = 1'b1;
    @(negedge clk);
    a_key_load = 1'b0;
    a_state = 4'h5; a_in_valid = 1'b1; a_out_ready = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    checks++;
    if (a_out !== 4'hF || a_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_xor: out=%h valid=%b required out=f valid=1", a_out, a_out_valid);
    end
    $display("txn basic: key=a state=5 out=%h valid=%b", a_out, a_out_valid);
  endtask

  task automatic test_backpressure();
    // FULL holding 4'hF, downstream stalled; offer state 0 -> 0^A = A.
    a_state = 4'h0; a_in_valid = 1'b1; a_out_ready = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready: in_ready=%b required 0", a_in_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (a_out !== 4'hF || a_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold: out=%h valid=%b required out=f valid=1", a_out, a_out_valid);
    end
    a_out_ready = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready: in_ready=%b required 1", a_in_ready);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    checks++;
    if (a_out !== 4'hA || a_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_next_word: out=%h valid=%b required out=a valid=1", a_out, a_out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (a_out !== 4'hA || a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain_empty: out=%h valid=%b required out=a valid=0", a_out, a_out_valid);
    end
    $display("txn backpressure: out=%h valid=%b", a_out, a_out_valid);
  endtask

  task automatic test_key_same_cycle();
    a_key = 4'h3; a_key_load = 1'b1;
    @(negedge clk);
    a_key = 4'hC; a_key_load = 1'b1;
    a_state = 4'h1; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    a_key_load = 1'b0;
    #1;
    checks++;
    if (a_out !== 4'h2 || a_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL key_old_used: out=%h valid=%b required out=2 valid=1", a_out, a_out_valid);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    checks++;
    if (a_out !== 4'hD || a_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL key_new_used: out=%h valid=%b required out=d valid=1", a_out, a_out_valid);
    end
    @(negedge clk);
    $display("txn key_same_cycle: last out=%h", a_out);
  endtask

  task automatic test_fault();
    // Key is 4'hC: state 1 gives p=D; the shadow path is forced with bit0 stuck at 0.
    a_clr_fault = 1'b1;
    #1;
    checks++;
    if (a_fault !== 1'b0 || a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL clr_outside_fault: fault=%b ready=%b required fault=0 ready=1", a_fault, a_in_ready);
    end
    a_clr_fault = 1'b0;
    a_state = 4'h1; a_in_valid = 1'b1;
    force dut_a.r_word = 4'hC;
    @(negedge clk);
    release dut_a.r_word;
    a_in_valid = 1'b0;
    #1;
    checks++;
    if (a_fault !== 1'b1 || a_out !== 4'h0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fault_entry: fault=%b out=%h valid=%b ready=%b required fault=1 out=0 valid=0 ready=0",
               a_fault, a_out, a_out_valid, a_in_ready);
    end
    a_state = 4'h6; a_in_valid = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (a_fault !== 1'b1 || a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fault_sticky: fault=%b valid=%b ready=%b required fault=1 valid=0 ready=0",
               a_fault, a_out_valid, a_in_ready);
    end
    a_in_valid = 1'b0; a_clr_fault = 1'b1;
    @(negedge clk);
    a_clr_fault = 1'b0;
    #1;
    checks++;
    if (a_fault !== 1'b0 || a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL fault_clear: fault=%b ready=%b valid=%b required fault=0 ready=1 valid=0",
               a_fault, a_in_ready, a_out_valid);
    end
    a_state = 4'h6; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    checks++;
    if (a_out !== 4'hA || a_out_valid !== 1'b1 || a_fault !== 1'b0) begin
      failures++;
      $display("FAIL fault_recover: out=%h valid=%b fault=%b required out=a valid=1 fault=0",
               a_out, a_out_valid, a_fault);
    end
    $display("txn fault: recovered out=%h fault=%b", a_out, a_fault);
  endtask

  task automatic test_reset_mid_full();
    // DUT is FULL with 4'hA and key 4'hC; reset must clear everything at once.
    a_out_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (a_out !== 4'h0 || a_out_valid !== 1'b0 || a_fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_full: out=%h valid=%b fault=%b required out=0 valid=0 fault=0",
               a_out, a_out_valid, a_fault);
    end
    @(negedge clk);
    rst = 1'b0;
    a_state = 4'h7; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    checks++;
    if (a_out !== 4'h7 || a_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_key_zero: out=%h valid=%b required out=7 valid=1", a_out, a_out_valid);
    end
    $display("txn reset_mid_full: post-reset out=%h", a_out);
  endtask

  task automatic test_stream();
    logic [127:0] key;
    logic [127:0] exp_q[$];
    logic [127:0] exp_w;
    int sent, recv, cyc;
    bit acc, take;
    sent = 0; recv = 0; cyc = 0;
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    b_key = key; b_key_load = 1'b1;
    @(negedge clk);
    b_key_load = 1'b0;
    while (recv < 1000 && cyc < 20000) begin
      b_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      b_state     = {$urandom(), $urandom(), $urandom(), $urandom()};
      b_out_ready = (sent >= 1000) || ($urandom_range(0, 2) != 0);
      #1;
      acc  = b_in_valid && b_in_ready;
      take = b_out_valid && b_out_ready;
      if (take) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++;
        if (b_out !== exp_w) begin
          failures++;
          if (failures < 20)
            $display("FAIL stream_word %0d: out=%h required %h", recv, b_out, exp_w);
        end
        recv++;
      end
      if (acc) begin
        exp_q.push_back(b_state ^ key);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    checks++;
    if (recv !== 1000 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL stream_count: received=%0d leftover=%0d required received=1000 leftover=0",
               recv, exp_q.size());
    end
    checks++;
    if (b_fault !== 1'b0) begin
      failures++;
      $display("FAIL stream_fault: fault=%b required 0", b_fault);
    end
    $display("txn stream: sent=%0d received=%0d cycles=%0d", sent, recv, cyc);
  endtask

  initial begin
    checks = 0; failures = 0;
    a_key = '0; a_key_load = 1'b0; a_in_valid = 1'b0; a_state = '0;
    a_out_ready = 1'b0; a_clr_fault = 1'b0;
    b_key = '0; b_key_load = 1'b0; b_in_valid = 1'b0; b_state = '0;
    b_out_ready = 1'b0; b_clr_fault = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_key_same_cycle();
    test_fault();
    test_reset_mid_full();
    test_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
